// File: rtl/fx_narrow_sat.sv
// Signed fixed-point narrowing converter: LSB quantization (round/floor) then
// MSB saturation or wrap, over a two-stage valid/ready pipeline with an overflow counter.
module fx_narrow_sat #(
   parameter int IN_W     = 14,
   parameter int IN_FRAC  = 2,
   parameter int OUT_W    = 12,
   parameter int OUT_FRAC = 1,
   parameter bit ROUND    = 1'b1,
   parameter bit SAT      = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [IN_W-1:0]  i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [OUT_W-1:0] o_data,
   output logic             o_ovf,
   input  logic             i_ovf_clr,
   output logic [CNT_W-1:0] o_ovf_cnt
);

   localparam int SH   = IN_FRAC - OUT_FRAC;
   localparam int R1_W = IN_W + 1 - SH;

   logic             v1;
   logic             v2;
   logic             adv1;
   logic             adv2;
   logic [R1_W-1:0]  r1;
   logic [R1_W-1:0]  q1;
   logic [IN_W:0]    ext;
   logic [IN_W:0]    biased;

   assign ext = {i_data[IN_W-1], i_data};

   // One extra headroom bit means adding the half-LSB can never overflow.
   generate
      if (SH > 0 && ROUND) begin : g_round
         assign biased = ext + ((IN_W + 1)'(1) << (SH - 1));
      end else begin : g_floor
         assign biased = ext;
      end
   endgenerate

   assign q1 = R1_W'($signed(biased) >>> SH);

   logic [R1_W-OUT_W:0] upper;
   logic                ovf2;
   logic [OUT_W-1:0]    d2;

   // In range exactly when every bit above the output sign bit matches it.
   assign upper = r1[R1_W-1:OUT_W-1];
   assign ovf2  = !((&upper) || !(|upper));

   always_comb begin
      d2 = r1[OUT_W-1:0];
      if (SAT && ovf2) begin
         d2 = r1[R1_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

   assign adv2    = !v2 || i_ready;
   assign adv1    = !v1 || adv2;
   assign o_ready = adv1;
   assign o_valid = v2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         r1 <= '0;
      end else if (adv1) begin
         v1 <= i_valid;
         if (i_valid) begin
            r1 <= q1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2     <= 1'b0;
         o_data <= '0;
         o_ovf  <= 1'b0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            o_data <= d2;
            o_ovf  <= ovf2;
         end
      end
   end

   logic ovf_hs;
   assign ovf_hs = v2 && i_ready && o_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_ovf_cnt <= '0;
      end else if (i_ovf_clr) begin
         o_ovf_cnt <= ovf_hs ? CNT_W'(1) : '0;
      end else if (ovf_hs && (o_ovf_cnt != {CNT_W{1'b1}})) begin
         o_ovf_cnt <= o_ovf_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fx_narrow_sat.sv
// Scoreboard bench for fx_narrow_sat: three instances (defaults, truncate,
// wrap with a 2-bit counter) share one stimulus stream and one expected queue.
module tb_fx_narrow_sat;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic [13:0] i_data;
   logic        i_ready;
   logic        i_ovf_clr;
   logic [2:0]  rdy;
   logic [2:0]  vld;
   logic [2:0]  ovf;
   logic [11:0] dat [3];
   logic [15:0] cnt_a;
   logic [15:0] cnt_r;
   logic [1:0]  cnt_w;

   int          n_chk = 0;
   int          n_pass = 0;
   bit          mon_en = 1'b0;
   bit          rnd_rdy = 1'b0;
   logic [13:0] in_q[$];

   localparam bit RND [3] = '{1'b1, 1'b0, 1'b1};
   localparam bit SATP[3] = '{1'b1, 1'b1, 1'b0};

   always #5 clk = ~clk;

   fx_narrow_sat dut_a (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[0]), .i_data(i_data),
      .o_valid(vld[0]), .i_ready(i_ready), .o_data(dat[0]), .o_ovf(ovf[0]),
      .i_ovf_clr(i_ovf_clr), .o_ovf_cnt(cnt_a)
   );

   fx_narrow_sat #(.ROUND(1'b0)) dut_r (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[1]), .i_data(i_data),
      .o_valid(vld[1]), .i_ready(i_ready), .o_data(dat[1]), .o_ovf(ovf[1]),
      .i_ovf_clr(i_ovf_clr), .o_ovf_cnt(cnt_r)
   );

   fx_narrow_sat #(.SAT(1'b0), .CNT_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[2]), .i_data(i_data),
      .o_valid(vld[2]), .i_ready(i_ready), .o_data(dat[2]), .o_ovf(ovf[2]),
      .i_ovf_clr(i_ovf_clr), .o_ovf_cnt(cnt_w)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference arithmetic in plain integers: +half-LSB, floor shift by 1, range test.
   function automatic void model(input logic [13:0] x, input bit rnd, input bit sat,
                                 output logic [11:0] d, output logic ov);
      int v;
      v = int'($signed(x));
      if (rnd) v = v + 1;
      v = v >>> 1;
      ov = (v > 2047) || (v < -2048);
      if (sat && ov) d = (v > 0) ? 12'h7FF : 12'h800;
      else           d = v[11:0];
   endfunction

   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("o_ready%0d", k), 32'(rdy[k]),
                  32'(!(in_q.size() == 2 && !i_ready)));
         end
         if (in_q.size() == 0) begin
            for (int k = 0; k < 3; k++) check($sformatf("valid_idle%0d", k), 32'(vld[k]), 0);
         end else if (vld[0]) begin
            for (int k = 0; k < 3; k++) begin
               logic [11:0] ed;
               logic        eo;
               model(in_q[0], RND[k], SATP[k], ed, eo);
               check($sformatf("o_valid%0d", k), 32'(vld[k]), 1);
               check($sformatf("o_data%0d in=%0h", k, in_q[0]), 32'(dat[k]), 32'(ed));
               check($sformatf("o_ovf%0d in=%0h", k, in_q[0]), 32'(ovf[k]), 32'(eo));
            end
            if (i_ready) void'(in_q.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic push_sample(input logic [13:0] x);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      i_valid = 1'b1;
      i_data  = x;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = rdy[0];
         @(posedge clk);
         n++;
      end
      if (acc) in_q.push_back(x);
      else     check("accept_timeout", 0, 1);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (in_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", in_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1; i_ovf_clr = 1'b0;
      #12;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_valid%0d", k), 32'(vld[k]), 0);
         check($sformatf("rst_data%0d", k), 32'(dat[k]), 0);
         check($sformatf("rst_ready%0d", k), 32'(rdy[k]), 1);
      end
      check("rst_cnt_a", 32'(cnt_a), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      idle(1);

      // Latency: accepted at edge N, visible after edge N+1.
      push_sample(14'd5);
      check("lat_n", 32'(vld[0]), 0);
      @(posedge clk);
      #1;
      check("lat_n1", 32'(vld[0]), 1);
      check("lat_data", 32'(dat[0]), 32'(12'd3));
      push_sample(14'h3FFB);
      push_sample(14'h1FFF);
      push_sample(14'h2000);
      idle(1);
      push_sample(14'h1FFF);
      drain();
      idle(2);
      check("cnt3_a", 32'(cnt_a), 3);
      check("cnt3_r", 32'(cnt_r), 3);
      check("cnt3_w", 32'(cnt_w), 3);

      // Clear coincident with a counted overflow handshake.
      push_sample(14'h1FFF);
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!vld[0] && n < 20);
         check("clr_wait", 32'(vld[0]), 1);
         i_ovf_clr = 1'b1;
         @(posedge clk);
         #1;
         i_ovf_clr = 1'b0;
      end
      check("clr_hs_a", 32'(cnt_a), 1);
      check("clr_hs_w", 32'(cnt_w), 1);
      drain();
      for (int i = 0; i < 5; i++) push_sample((i % 2 == 0) ? 14'h1FFF : 14'h2000);
      drain();
      idle(2);
      check("cnt6_a", 32'(cnt_a), 6);
      check("cnt_sat_w", 32'(cnt_w), 3);

      // Random backpressure: ordered 0..9, then wider random values.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push_sample(14'(i));
         if (i == 4) idle(2);
      end
      for (int i = 0; i < 24; i++) push_sample(14'($urandom));
      rnd_rdy = 1'b0;
      @(posedge clk);
      #2;
      i_ready = 1'b1;
      drain();

      // Mid-stream async reset with both stages full.
      i_ready = 1'b0;
      push_sample(14'd100);
      push_sample(14'd200);
      @(negedge clk);
      check("full_ready", 32'(rdy[0]), 0);
      #2;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("arst_valid%0d", k), 32'(vld[k]), 0);
         check($sformatf("arst_data%0d", k), 32'(dat[k]), 0);
         check($sformatf("arst_ready%0d", k), 32'(rdy[k]), 1);
      end
      check("arst_cnt_a", 32'(cnt_a), 0);
      check("arst_cnt_w", 32'(cnt_w), 0);
      in_q.delete();
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      push_sample(14'h3FFB);
      drain();
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
